// File: rtl/aes_inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns engine. A 128-bit state is captured and then
// transformed in place, COLS_PER_CYCLE columns per cycle. The same register
// is presented as out_data once every column has been processed.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// Both are decoded from the state register alone, so neither depends
// combinationally on any input. The input and output transfers never share
// an edge.
module aes_inv_mixcolumns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("aes_inv_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Counter step. With four columns per cycle this truncates to 0, so cnt
  // stays at 0 and the single BUSY cycle is always the last group.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q;
  logic [127:0] data_q;
  logic [127:0] data_xf;
  logic         last_group;

  // GF(2^8) multiply by x, reduced by the AES polynomial (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns of one column. Row 0 is the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31 - 8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Bit offset of the LSB of column (c + k) mod 4. Column 0 sits at [127:96].
  function automatic int col_lsb(input logic [1:0] c, input int k);
    logic [1:0] idx;
    idx = c + 2'(k);
    return 96 - 32 * int'(idx);
  endfunction

  // The group is last when the counter wraps back to column 0.
  assign last_group = ((cnt_q + CNT_STEP) == 2'b00);

  // Replace the columns addressed by cnt with their transformed values.
  always_comb begin
    data_xf = data_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      data_xf[col_lsb(cnt_q, k) +: 32] = inv_mix_col(data_q[col_lsb(cnt_q, k) +: 32]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. In IDLE a valid input is taken. In BUSY the input is
  // ignored until the last group. In DONE the result is held until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_group) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column counter. It restarts at 0 on capture and steps once per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'b00;
    end else if (state_q == IDLE && in_valid) begin
      cnt_q <= 2'b00;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CNT_STEP;
    end
  end

  // State data register, which is also the output register.
  // It changes only on capture, on BUSY edges and on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      data_q <= in_data;
    end else if (state_q == BUSY) begin
      data_q <= data_xf;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign out_data  = data_q;

endmodule
